// File: rtl/player_ctrl.sv
// Player heart controller: keyboard movement with saturation, per-frame bullet
// collision, hit points, invulnerability window and death/restart sequencing.
//
// state  | meaning
// -------+--------------------------------------------------------------
// WAIT   | idle, collecting key presses until the next frame_tick
// UPDATE | apply pending moves, age the invulnerability counter
// CHECK  | compare updated position against the bullet, apply damage
// DEAD   | hp exhausted; everything frozen until an 'r' key press
module player_ctrl #(
   parameter int AREA_MAX   = 183,
   parameter int STEP       = 2,
   parameter int START_X    = 92,
   parameter int START_Y    = 92,
   parameter int HP_INIT    = 20,
   parameter int DMG        = 4,
   parameter int HIT_R      = 8,
   parameter int INV_FRAMES = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   input  logic [15:0] bullet_pos,
   input  logic        bullet_active,
   output logic [15:0] player_pos,
   output logic [7:0]  hp,
   output logic        hit,
   output logic        invuln,
   output logic        dead
);

   typedef enum logic [1:0] {S_WAIT, S_UPDATE, S_CHECK, S_DEAD} state_t;

   localparam logic signed [9:0] STEP_S  = 10'(STEP);
   localparam logic signed [9:0] AREA_S  = 10'(AREA_MAX);
   localparam logic [7:0]        AREA8   = 8'(AREA_MAX);
   localparam logic [7:0]        START_X8 = 8'(START_X);
   localparam logic [7:0]        START_Y8 = 8'(START_Y);
   localparam logic [7:0]        HP_INIT8 = 8'(HP_INIT);
   localparam logic [7:0]        DMG8    = 8'(DMG);
   localparam logic [7:0]        HIT_R8  = 8'(HIT_R);
   localparam logic [15:0]       INV_LD  = 16'(INV_FRAMES);

   state_t      state, state_nxt;
   logic [7:0]  pos_x, pos_y, hp_q;
   logic [3:0]  pend;      // {right, down, left, up}
   logic [3:0]  key_dir;
   logic [15:0] inv_cnt;
   logic        hit_q;
   logic        restart, near, take_hit;
   logic [7:0]  x_new, y_new, adx, ady, hp_after;
   logic signed [9:0] x_calc, y_calc;

   always_comb begin
      key_dir = 4'b0000;
      if (key_valid) begin
         case (key_code)
            8'h77:   key_dir = 4'b0001;
            8'h61:   key_dir = 4'b0010;
            8'h73:   key_dir = 4'b0100;
            8'h64:   key_dir = 4'b1000;
            default: key_dir = 4'b0000;
         endcase
      end
   end

   assign restart = key_valid && (key_code == 8'h72);

   // Signed 10-bit arithmetic so underflow shows up as negative, not a wrap.
   always_comb begin
      x_calc = $signed({2'b00, pos_x});
      y_calc = $signed({2'b00, pos_y});
      if (pend[3] && !pend[1])      x_calc = x_calc + STEP_S;
      else if (pend[1] && !pend[3]) x_calc = x_calc - STEP_S;
      if (pend[2] && !pend[0])      y_calc = y_calc + STEP_S;
      else if (pend[0] && !pend[2]) y_calc = y_calc - STEP_S;
      if (x_calc < 0)           x_new = 8'd0;
      else if (x_calc > AREA_S) x_new = AREA8;
      else                      x_new = x_calc[7:0];
      if (y_calc < 0)           y_new = 8'd0;
      else if (y_calc > AREA_S) y_new = AREA8;
      else                      y_new = y_calc[7:0];
   end

   always_comb begin
      adx = (bullet_pos[7:0]  >= pos_x) ? bullet_pos[7:0]  - pos_x : pos_x - bullet_pos[7:0];
      ady = (bullet_pos[15:8] >= pos_y) ? bullet_pos[15:8] - pos_y : pos_y - bullet_pos[15:8];
      near     = (adx <= HIT_R8) && (ady <= HIT_R8);
      take_hit = (state == S_CHECK) && bullet_active && near && (inv_cnt == 16'd0);
      hp_after = (hp_q > DMG8) ? hp_q - DMG8 : 8'd0;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:   if (frame_tick) state_nxt = S_UPDATE;
         S_UPDATE: state_nxt = S_CHECK;
         S_CHECK:  state_nxt = (take_hit && hp_after == 8'd0) ? S_DEAD : S_WAIT;
         S_DEAD:   if (restart) state_nxt = S_WAIT;
         default:  state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_WAIT;
         pos_x   <= START_X8;
         pos_y   <= START_Y8;
         hp_q    <= HP_INIT8;
         hit_q   <= 1'b0;
         inv_cnt <= 16'd0;
         pend    <= 4'b0000;
      end else begin
         state <= state_nxt;
         hit_q <= 1'b0;
         case (state)
            S_WAIT: pend <= pend | key_dir;
            S_UPDATE: begin
               pos_x <= x_new;
               pos_y <= y_new;
               // a press landing on the clearing edge is kept for next frame
               pend  <= key_dir;
               if (inv_cnt != 16'd0) inv_cnt <= inv_cnt - 16'd1;
            end
            S_CHECK: begin
               pend <= pend | key_dir;
               if (take_hit) begin
                  hp_q    <= hp_after;
                  hit_q   <= 1'b1;
                  inv_cnt <= INV_LD;
               end
            end
            default: begin
               pend <= 4'b0000;
               if (restart) begin
                  pos_x   <= START_X8;
                  pos_y   <= START_Y8;
                  hp_q    <= HP_INIT8;
                  inv_cnt <= 16'd0;
               end
            end
         endcase
      end
   end

   assign player_pos = {pos_y, pos_x};
   assign hp         = hp_q;
   assign hit        = hit_q;
   assign invuln     = (inv_cnt != 16'd0);
   assign dead       = (state == S_DEAD);

endmodule
